// File: rtl/cube_root_if.sv
// cube_root_if: clock-enable, start/done handshake and result bus of the cube-root unit
interface cube_root_if;
  logic        i_clkEn;
  logic        i_start;
  logic [23:0] i_x;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_root;
  logic [23:0] o_remainder;
  modport master (output i_clkEn, i_start, i_x, input o_busy, o_done, o_root, o_remainder);
  modport slave  (input i_clkEn, i_start, i_x, output o_busy, o_done, o_root, o_remainder);
endinterface

// File: rtl/cube_root.sv
// cube_root: bit-serial floor(cbrt(x)) of a 24-bit radicand, two enabled cycles per root bit.
// Define CUBE_ROOT_REMAINDER_EN to also produce x - root^3; otherwise o_remainder is 0.
module cube_root (
  input logic       i_clk,
  input logic       i_arstn,
  cube_root_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SQ, CMP} state_t;
  state_t      state_q, state_d;
  logic [23:0] x_q, x_d;
  logic [7:0]  root_q, root_d, res_q, res_d;
  logic [2:0]  k_q, k_d;
  logic [15:0] sq_q, sq_d;
  logic        done_q, done_d;
  logic [7:0]  cand;
  logic [23:0] cube;
  logic        hit;
  assign cand = root_q | (8'd1 << k_q);
  assign cube = 24'(sq_q) * 24'(cand);
  assign hit  = cube <= x_q;
`ifdef CUBE_ROOT_REMAINDER_EN
  logic [23:0] rem_q, rem_d, acc_q, acc_d;
  // acc_q holds the cube of the last accepted candidate, which equals root_q^3
  always_comb begin
    rem_d = rem_q;
    acc_d = acc_q;
    if (state_q == IDLE && bus.i_start) acc_d = '0;
    if (state_q == CMP && hit) acc_d = cube;
    if (state_q == CMP && k_q == 3'd0) rem_d = x_q - (hit ? cube : acc_q);
  end
  always_ff @(posedge i_clk or negedge i_arstn)
    if (!i_arstn) begin
      rem_q <= '0;
      acc_q <= '0;
    end else if (bus.i_clkEn) begin
      rem_q <= rem_d;
      acc_q <= acc_d;
    end
  assign bus.o_remainder = rem_q;
`else
  assign bus.o_remainder = '0;
`endif
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    root_d  = root_q;
    res_d   = res_q;
    k_d     = k_q;
    sq_d    = sq_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        x_d     = bus.i_x;
        root_d  = '0;
        k_d     = 3'd7;
        state_d = SQ;
      end
      SQ: begin
        sq_d    = 16'(cand) * 16'(cand);
        state_d = CMP;
      end
      CMP: begin
        root_d = hit ? cand : root_q;
        if (k_q != 3'd0) begin
          k_d     = k_q - 3'd1;
          state_d = SQ;
        end else begin
          res_d   = hit ? cand : root_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_arstn)
    if (!i_arstn) begin
      state_q <= IDLE;
      x_q     <= '0;
      root_q  <= '0;
      res_q   <= '0;
      k_q     <= '0;
      sq_q    <= '0;
      done_q  <= 1'b0;
    end else if (bus.i_clkEn) begin
      state_q <= state_d;
      x_q     <= x_d;
      root_q  <= root_d;
      res_q   <= res_d;
      k_q     <= k_d;
      sq_q    <= sq_d;
      done_q  <= done_d;
    end
  assign bus.o_busy = state_q != IDLE;
  assign bus.o_done = done_q;
  assign bus.o_root = res_q;
endmodule
